// File: rtl/hazard_stall_unit.sv
// ID-stage hazard detector and stall sequencer for load-use and ID-resolved beq/bne hazards.
// Optional performance counters are enabled with `define HAZARD_PERF_CNT_EN.
module hazard_stall_unit #(
   parameter int unsigned CNT_W          = 16,
   parameter int unsigned BR_LOAD_STALLS = 2
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [31:0]      i_id_instru,
   input  logic             i_id_beq,
   input  logic             i_id_bne,
   input  logic             i_id_branch_taken,
   input  logic             i_ex_MemRead,
   input  logic             i_ex_RegWrite,
   input  logic [4:0]       i_ex_wReg,
   output logic             o_c_PC_write,
   output logic             o_c_IF_ID_write,
   output logic             o_c_ID_EX_bubble,
   output logic             o_c_IF_ID_flush,
   output logic             o_stall_busy,
   output logic [CNT_W-1:0] o_stall_cycles,
   output logic [CNT_W-1:0] o_branch_flushes
);

   typedef enum logic [0:0] {StIdle, StHold} state_e;

   state_e     r_state, w_state_d;
   logic [1:0] r_remain, w_remain_d;

   logic [5:0] w_opcode;
   logic [4:0] w_rs, w_rt;
   logic       w_uses_rt, w_match, w_br;
   logic       w_haz_l, w_haz_ba, w_haz_bl, w_hazard;
   logic [1:0] w_total_m1;
   logic       w_stall, w_flush;

   assign w_opcode  = i_id_instru[31:26];
   assign w_rs      = i_id_instru[25:21];
   assign w_rt      = i_id_instru[20:16];
   assign w_uses_rt = (w_opcode == 6'h00) || (w_opcode == 6'h04) ||
                      (w_opcode == 6'h05) || (w_opcode == 6'h2B);
   assign w_match   = (i_ex_wReg != 5'd0) &&
                      ((i_ex_wReg == w_rs) || (w_uses_rt && (i_ex_wReg == w_rt)));
   assign w_br      = i_id_beq | i_id_bne;

   assign w_haz_l    = i_ex_MemRead & w_match & ~w_br;
   assign w_haz_ba   = w_br & i_ex_RegWrite & ~i_ex_MemRead & w_match;
   assign w_haz_bl   = w_br & i_ex_MemRead & w_match;
   assign w_hazard   = w_haz_l | w_haz_ba | w_haz_bl;
   assign w_total_m1 = w_haz_bl ? 2'(BR_LOAD_STALLS - 1) : 2'd0;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state  <= StIdle;
         r_remain <= 2'd0;
      end else begin
         r_state  <= w_state_d;
         r_remain <= w_remain_d;
      end
   end

   // In HOLD the counter owns the window; ID inputs are ignored until it drains.
   always_comb begin
      w_stall    = 1'b0;
      w_state_d  = r_state;
      w_remain_d = r_remain;
      unique case (r_state)
         StIdle: begin
            if (w_hazard) begin
               w_stall    = 1'b1;
               w_remain_d = w_total_m1;
               w_state_d  = (w_total_m1 != 2'd0) ? StHold : StIdle;
            end
         end
         StHold: begin
            w_stall    = 1'b1;
            w_remain_d = r_remain - 2'd1;
            w_state_d  = (r_remain == 2'd1) ? StIdle : StHold;
         end
      endcase
   end

   assign w_flush = w_br & i_id_branch_taken & ~w_stall & i_rst_n;

   always_comb begin
      o_c_PC_write     = ~w_stall;
      o_c_IF_ID_write  = ~w_stall;
      o_c_ID_EX_bubble = w_stall;
      if (!i_rst_n) begin
         o_c_PC_write     = 1'b1;
         o_c_IF_ID_write  = 1'b1;
         o_c_ID_EX_bubble = 1'b0;
      end
   end

   assign o_c_IF_ID_flush = w_flush;
   assign o_stall_busy    = (r_state == StHold);

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] r_stall_cycles, r_branch_flushes;

   // Both counters saturate at all-ones.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_stall_cycles   <= '0;
         r_branch_flushes <= '0;
      end else begin
         if (w_stall && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + 1'b1;
         if (w_flush && (r_branch_flushes != '1)) r_branch_flushes <= r_branch_flushes + 1'b1;
      end
   end

   assign o_stall_cycles   = r_stall_cycles;
   assign o_branch_flushes = r_branch_flushes;
`else
   assign o_stall_cycles   = '0;
   assign o_branch_flushes = '0;
`endif

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- ID-stage hazard detection and stall sequencer; counterpart of the EX-stage forwarding unit.
- Forwarding consumes EX/MEM and MEM/WB write-back results. This block covers the cases forwarding cannot: it freezes PC and IF/ID, and injects bubbles into ID/EX.
- Covers load-use hazards and hazards on ID-resolved beq/bne.
- A registered stall counter holds multi-cycle stalls, so the block needs EX-stage information only.

Parameters:
- CNT_W, 16, width of the performance counters.
- BR_LOAD_STALLS, 2, total stall cycles when a beq/bne in ID reads a register loaded by lw in EX. Legal values 1..3.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous reset, active-low.
- id_instru  input  32  IF/ID.instru; rs=[25:21], rt=[20:16], opcode=[31:26].
- id_beq  input  1  ID decodes beq.
- id_bne  input  1  ID decodes bne.
- id_branch_taken  input  1  ID comparator result (valid only with id_beq|id_bne).
- ex_MemRead  input  1  ID/EX.MemRead.
- ex_RegWrite  input  1  ID/EX.RegWrite.
- ex_wReg  input  5  ID/EX destination register (already muxed rt/rd).
- c_PC_write  output  1  PC load enable.
- c_IF_ID_write  output  1  IF/ID load enable.
- c_ID_EX_bubble  output  1  zero all ID/EX control bits this cycle.
- c_IF_ID_flush  output  1  replace IF/ID content with nop at next edge.
- stall_busy  output  1  registered counter active (status).
- stall_cycles  output  CNT_W  performance counter.
- branch_flushes  output  CNT_W  performance counter.

Behaviour:
- uses_rt = opcode in {0x00, 0x04, 0x05, 0x2B}; uses_rs is always 1.
- match = (ex_wReg != 0) & ((ex_wReg == rs) | (uses_rt & ex_wReg == rt)).
- br = id_beq | id_bne.
- Hazard classes, evaluated in IDLE only:
  - L: load-use. ex_MemRead & match & !br. Total stall = 1.
  - BA: branch on ALU result. br & ex_RegWrite & !ex_MemRead & match. Total stall = 1.
  - BL: branch on load. br & ex_MemRead & match. Total stall = BR_LOAD_STALLS.
- States:
  - IDLE: remain = 0.
  - HOLD: remain > 0.
- Cycle T, IDLE with a hazard:
  - stall asserted combinationally in T.
  - remain <= total - 1; go to HOLD if nonzero, else stay in IDLE.
- HOLD:
  - stall asserted unconditionally; remain decrements each edge.
  - Return to IDLE when remain reaches 0 at the edge.
  - Hazard inputs are ignored in HOLD; the counter owns the window.
- Stall asserted means c_PC_write=0, c_IF_ID_write=0, c_ID_EX_bubble=1.
- Not stalled means c_PC_write=1, c_IF_ID_write=1, c_ID_EX_bubble=0.
- c_IF_ID_flush = br & id_branch_taken & !stall & rst_n. The stall takes priority: a taken branch is not flushed until its operands are resolved.
- stall_busy = (state == HOLD).
- Reset (rst_n=0 at an edge):
  - remain=0, state IDLE, counters 0.
  - While rst_n=0 the outputs are forced to c_PC_write=1, c_IF_ID_write=1, c_ID_EX_bubble=0, c_IF_ID_flush=0.
  - Reset mid-HOLD aborts the stall at that edge.
- ex_wReg==0 never causes a stall.
- Simultaneous L and BL cannot both occur; BL wins by definition (!br in L).

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cycles increments on each non-reset edge where stall is asserted.
  - branch_flushes increments on each edge where c_IF_ID_flush=1.
  - Both counters saturate at all-ones.
- Undefined: both counters are omitted and the outputs are tied to 0.

Test Plan:
- lw $t0 in EX (ex_MemRead=1, ex_wReg=8) with add using rs=8 in ID -> exactly 1 cycle of c_PC_write=0/c_ID_EX_bubble=1, stall_busy stays 0.
- lw $t0 in EX with beq rs=8 in ID, BR_LOAD_STALLS=2 -> stall for 2 consecutive cycles, stall_busy=1 in the second only. If the branch is taken, c_IF_ID_flush=1 in cycle 3; stall_cycles=2.
- addi $t1 in EX (RegWrite=1, wReg=9) with bne rt=9 in ID -> 1-cycle stall, then flush when taken; ex_wReg=0 with rs=0 -> no stall.
- sw with rt=8 after lw $8 -> stall (uses_rt); lw with rt=8 after lw $8 -> no stall (rt not a source).
- Assert rst_n=0 in cycle 2 of a BL stall -> next cycle c_PC_write=1, stall_busy=0, counters 0.
- With HAZARD_PERF_CNT_EN, CNT_W=2 and 5 stall cycles -> stall_cycles holds 3; without the macro -> stall_cycles reads 0.
